// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared definitions for the sequential BCD-to-binary converter
//
// Purpose: FSM state encoding, the largest legal BCD digit and the
//          accumulator width derivation used by bcd2bin_seq and bcd_digit_mac.
// Ports:   none (package).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int BCD_MAX_DIGIT = 9;

  // 4 bits per digit always covers 10^digits-1, so the
  // acc*10+d recurrence never wraps.
  function automatic int acc_width(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - combinational acc*10+digit step with invalid-digit flag
//
// Purpose: one step of the most-significant-digit-first BCD conversion.
// Ports:
//   acc    in  ACC_W  running accumulator
//   digit  in  4      BCD digit to fold in
//   result out ACC_W  acc*10 + digit (digit forced to 0 when invalid)
//   bad    out 1      digit was greater than 9
module bcd_digit_mac import bcd_pkg::*; #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] result,
  output logic             bad
);

  logic [ACC_W+3:0] wide;
  logic [3:0]       d_eff;

  always_comb begin
    bad    = (digit > 4'(BCD_MAX_DIGIT));
    d_eff  = bad ? 4'd0 : digit;
    // acc*10 as (acc<<3)+(acc<<1); kept wide, then truncated since the
    // accumulator width already bounds the true result.
    wide   = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + (ACC_W + 4)'(d_eff);
    result = wide[ACC_W-1:0];
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential sign-magnitude BCD to binary converter
//
// Purpose: converts DIGITS BCD digits (MSD first, one per clock) to a
//          saturated BIN_W-bit magnitude, output as sign-magnitude or
//          two's complement, with valid/ready on both sides.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   in   input word valid
//   in_ready   out  converter idle and accepting
//   in_bcd     in   4*DIGITS BCD digits, digit 0 in [3:0]
//   in_sign    in   1 = negative
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   out_data   out  BIN_W+1 bit result
//   out_err    out  some digit was > 9
//   out_ovf    out  magnitude saturated to 2^BIN_W-1
module bcd2bin_seq import bcd_pkg::*; #(
  parameter int DIGITS    = 2,
  parameter int BIN_W     = 8,
  parameter bit TWOS_COMP = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  input  logic                in_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W:0]      out_data,
  output logic                out_err,
  output logic                out_ovf
);

  localparam int ACC_W = acc_width(DIGITS);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int CMP_W = (ACC_W > BIN_W) ? ACC_W : BIN_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t             state, state_next;
  logic [ACC_W-1:0]   bcd_sh, acc, mac_result;
  logic [CNT_W-1:0]   cnt;
  logic               sign, err, mac_bad;
  logic               accept, last_digit;
  logic [CMP_W-1:0]   acc_ext;
  logic               sat, neg;
  logic [BIN_W-1:0]   mag;
  logic [BIN_W:0]     result;

  // Captured digits are shifted left each step, so the top nibble is
  // always digit DIGITS-1-cnt.
  bcd_digit_mac #(.ACC_W(ACC_W)) u_mac (
    .acc    (acc),
    .digit  (bcd_sh[ACC_W-1 -: 4]),
    .result (mac_result),
    .bad    (mac_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CONVERT;
      end
      CONVERT: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign last_digit = (state == CONVERT) && (cnt == LAST);

  // Output formatting works on the MAC output so the result is
  // registered on the same edge that folds in the last digit.
  always_comb begin
    acc_ext = CMP_W'(mac_result);
    sat     = |(acc_ext >> BIN_W);
    mag     = sat ? '1 : acc_ext[BIN_W-1:0];
    neg     = sign && (mag != '0);   // -0 is reported as +0
    if (TWOS_COMP) result = neg ? -{1'b0, mag} : {1'b0, mag};
    else           result = {neg, mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      bcd_sh   <= '0;
      sign     <= 1'b0;
      err      <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      bcd_sh <= in_bcd;
      sign   <= in_sign;
      acc    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (state == CONVERT) begin
      acc    <= mac_result;
      bcd_sh <= bcd_sh << 4;
      cnt    <= cnt + 1'b1;
      err    <= err | mac_bad;
      if (last_digit) begin
        out_data <= result;
        out_err  <= err | mac_bad;
        out_ovf  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - scoreboard bench for bcd2bin_seq in three configurations
module tb_bcd2bin_seq;

  typedef struct packed {
    logic [8:0] data;
    logic       err;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [11:0] in_bcd    [3];
  logic        in_sign   [3];
  logic        out_valid [3];
  logic        out_ready [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0]  out_data  [3];
  logic        out_err   [3];
  logic        out_ovf   [3];
  int          ready_mode[3];   // 0 random, 1 hold low, 2 hold high

  int errors = 0;
  int checks = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  // 0: DIGITS=2 sign-magnitude, 1: DIGITS=2 two's complement, 2: DIGITS=3 sign-magnitude
  bcd2bin_seq #(.DIGITS(2), .BIN_W(8), .TWOS_COMP(1'b0)) u_sm2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_bcd(in_bcd[0][7:0]), .in_sign(in_sign[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_err(out_err[0]), .out_ovf(out_ovf[0]));
  bcd2bin_seq #(.DIGITS(2), .BIN_W(8), .TWOS_COMP(1'b1)) u_tc2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_bcd(in_bcd[1][7:0]), .in_sign(in_sign[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_err(out_err[1]), .out_ovf(out_ovf[1]));
  bcd2bin_seq #(.DIGITS(3), .BIN_W(8), .TWOS_COMP(1'b0)) u_sm3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_bcd(in_bcd[2]), .in_sign(in_sign[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_err(out_err[2]), .out_ovf(out_ovf[2]));

  function automatic int digs(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  // Reference: decimal value of the digits, saturate, then encode the sign.
  function automatic exp_t model(int i, logic [11:0] bcd, logic sign);
    exp_t e;
    int   val = 0;
    int   mag;
    bit   neg;
    e.err = 1'b0;
    for (int k = digs(i) - 1; k >= 0; k--) begin
      int n = (int'(bcd) >> (4 * k)) & 15;
      if (n > 9) begin
        e.err = 1'b1;
        n = 0;
      end
      val = val * 10 + n;
    end
    e.ovf = (val > 255);
    mag   = e.ovf ? 255 : val;
    neg   = sign && (mag != 0);
    if (i == 1) e.data = 9'(neg ? (512 - mag) : mag);
    else        e.data = 9'(neg ? (256 + mag) : mag);
    return e;
  endfunction

  function automatic void qpush(int i, exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready, updated after the driver's own post-edge activity.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      case (ready_mode[i])
        0:       out_ready[i] = 1'($urandom_range(0, 1));
        1:       out_ready[i] = 1'b0;
        default: out_ready[i] = 1'b1;
      endcase
    end
  end

  // Monitor: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && out_valid[i] && out_ready[i]) begin
        exp_t e;
        if (qsize(i) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output[%0d]: got data 0x%0h, expected no output", i, out_data[i]);
        end else begin
          e = qpop(i);
          chk($sformatf("out_data[%0d]", i), int'(out_data[i]), int'(e.data));
          chk($sformatf("out_err[%0d]", i),  int'(out_err[i]),  int'(e.err));
          chk($sformatf("out_ovf[%0d]", i),  int'(out_ovf[i]),  int'(e.ovf));
        end
      end
    end
  end

  // Issue one word; returns just after the accepting edge, or, with
  // lat_chk, at the sample point where out_valid must first be high.
  task automatic send(int i, logic [11:0] bcd, logic sign, exp_t e, bit lat_chk, bit do_push);
    bit ok = 0;
    bit rdy;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b1;
    in_bcd[i]   = bcd;
    in_sign[i]  = sign;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      rdy = in_ready[i];
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
    end
    in_valid[i] = 1'b0;
    in_bcd[i]   = 12'($urandom);
    in_sign[i]  = 1'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout[%0d]: got no accept, expected accept within 200 cycles", i);
    end else begin
      if (do_push) qpush(i, e);
      if (lat_chk) begin
        for (int j = 1; j <= digs(i) + 1; j++) begin
          @(negedge clk);
          chk($sformatf("latency[%0d] cycle %0d out_valid", i, j - 1),
              int'(out_valid[i]), (j == digs(i) + 1) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic drain();
    bit empty = 0;
    for (int c = 0; c < 300 && !empty; c++) begin
      @(negedge clk);
      empty = (qsize(0) == 0) && (qsize(1) == 0) && (qsize(2) == 0);
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending results, expected 0", qsize(0), qsize(1), qsize(2));
    end
  endtask

  task automatic directed(int i, logic [11:0] bcd, logic sign, logic [8:0] d, logic er, logic ov, bit lat);
    exp_t e;
    e.data = d;
    e.err  = er;
    e.ovf  = ov;
    send(i, bcd, sign, e, lat, 1'b1);
  endtask

  initial begin
    exp_t none;
    none = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]   = 1'b0;
      in_bcd[i]     = '0;
      in_sign[i]    = 1'b0;
      ready_mode[i] = 2;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset in_ready[%0d]", i),  int'(in_ready[i]),  1);
      chk($sformatf("reset out_valid[%0d]", i), int'(out_valid[i]), 0);
      chk($sformatf("reset out_data[%0d]", i),  int'(out_data[i]),  0);
      chk($sformatf("reset out_err[%0d]", i),   int'(out_err[i]),   0);
      chk($sformatf("reset out_ovf[%0d]", i),   int'(out_ovf[i]),   0);
    end

    // Directed vectors with hand-derived results.
    directed(0, 12'h047, 1'b0, 9'h02F, 1'b0, 1'b0, 1'b1);
    directed(1, 12'h047, 1'b1, 9'h1D1, 1'b0, 1'b0, 1'b0);
    directed(0, 12'h047, 1'b1, 9'h12F, 1'b0, 1'b0, 1'b0);
    directed(0, 12'h000, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0);
    directed(1, 12'h000, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0);
    directed(0, 12'h04A, 1'b0, 9'h028, 1'b1, 1'b0, 1'b0);
    directed(0, 12'h012, 1'b0, 9'h00C, 1'b0, 1'b0, 1'b0);
    directed(2, 12'h999, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b1);
    directed(2, 12'h255, 1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0);
    directed(2, 12'h256, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0);
    directed(1, 12'h099, 1'b1, 9'h19D, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: hold out_ready low, offer a competing input meanwhile.
    ready_mode[0] = 1;
    directed(0, 12'h093, 1'b1, 9'h15D, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_bcd[0]   = 12'h011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall out_valid", int'(out_valid[0]), 1);
      chk("stall out_data",  int'(out_data[0]),  'h15D);
      chk("stall in_ready",  int'(in_ready[0]),  0);
    end
    @(posedge clk);
    #1;
    in_valid[0]   = 1'b0;
    ready_mode[0] = 2;
    @(negedge clk);
    @(negedge clk);
    chk("release in_ready",  int'(in_ready[0]),  1);
    chk("release out_valid", int'(out_valid[0]), 0);
    drain();

    // Reset landing on the first CONVERT cycle discards the word.
    send(2, 12'h123, 1'b0, none, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst in_ready",  int'(in_ready[2]),  1);
    chk("mid_rst out_valid", int'(out_valid[2]), 0);
    chk("mid_rst out_data",  int'(out_data[2]),  0);
    chk("mid_rst out_err",   int'(out_err[2]),   0);
    chk("mid_rst out_ovf",   int'(out_ovf[2]),   0);
    directed(2, 12'h187, 1'b1, 9'h1BB, 1'b0, 1'b0, 1'b1);
    drain();

    // Randomised words under random backpressure, checked against the model.
    for (int i = 0; i < 3; i++) ready_mode[i] = 0;
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 20; t++) begin
        logic [11:0] b;
        logic        s;
        b = '0;
        for (int k = 0; k < digs(i); k++) begin
          int n;
          n = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
          b[4*k +: 4] = 4'(n);
        end
        s = 1'($urandom);
        send(i, b, s, model(i, b, s), (t == 0), 1'b1);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
